// File: rtl/fll_pkg.sv
// Shared FLL types and helpers: state encoding plus the clipping function
// used by both this controller and the NCO.
package fll_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACQUIRE = 2'd1,
        TRACK   = 2'd2
    } fll_state_t;

    localparam logic [1:0] StateIdle    = 2'd0;
    localparam logic [1:0] StateAcquire = 2'd1;
    localparam logic [1:0] StateTrack   = 2'd2;

    // Callers sign-extend into 64 bits so one helper serves any word width.
    function automatic logic signed [63:0] saturate(input logic signed [63:0] value,
                                                    input logic signed [63:0] limit);
        if (value > limit) begin
            return limit;
        end else if (value < -limit) begin
            return -limit;
        end
        return value;
    endfunction

    function automatic logic exceeds_limit(input logic signed [63:0] value,
                                           input logic signed [63:0] limit);
        return (value > limit) || (value < -limit);
    endfunction

endpackage

// File: rtl/lock_detector.sv
// Threshold compare plus saturating runs of consecutive in-lock and
// out-of-lock samples; the reached strobes fire on the sample that completes a run.
module lock_detector #(
    parameter int ErrorBits     = 12,
    parameter int LockThreshold = 64,
    parameter int LockCount     = 256,
    parameter int UnlockCount   = 16
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic                        sample_i,
    input  logic                        clear_i,
    input  logic signed [ErrorBits-1:0] err_i,
    output logic                        in_lock_reached_o,
    output logic                        out_lock_reached_o
);

    localparam int InCntBits  = $clog2(LockCount + 1);
    localparam int OutCntBits = $clog2(UnlockCount + 1);

    logic signed [ErrorBits:0] err_wide;
    logic        [ErrorBits:0] magnitude;
    logic                      in_lock;
    logic [InCntBits-1:0]      in_cnt_q, in_cnt_d;
    logic [OutCntBits-1:0]     out_cnt_q, out_cnt_d;

    // One extra bit so the most negative error has a representable magnitude.
    always_comb begin
        err_wide  = (ErrorBits + 1)'(err_i);
        magnitude = err_wide[ErrorBits] ? unsigned'(-err_wide) : unsigned'(err_wide);
        in_lock   = magnitude <= (ErrorBits + 1)'(LockThreshold);
    end

    always_comb begin
        in_cnt_d  = in_cnt_q;
        out_cnt_d = out_cnt_q;
        if (clear_i) begin
            in_cnt_d  = '0;
            out_cnt_d = '0;
        end else if (sample_i) begin
            if (in_lock) begin
                out_cnt_d = '0;
                if (in_cnt_q != InCntBits'(LockCount)) begin
                    in_cnt_d = in_cnt_q + 1'b1;
                end
            end else begin
                in_cnt_d = '0;
                if (out_cnt_q != OutCntBits'(UnlockCount)) begin
                    out_cnt_d = out_cnt_q + 1'b1;
                end
            end
        end
    end

    assign in_lock_reached_o  = sample_i && in_lock && (in_cnt_q == InCntBits'(LockCount - 1));
    assign out_lock_reached_o = sample_i && !in_lock && (out_cnt_q == OutCntBits'(UnlockCount - 1));

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            in_cnt_q  <= '0;
            out_cnt_q <= '0;
        end else begin
            in_cnt_q  <= in_cnt_d;
            out_cnt_q <= out_cnt_d;
        end
    end

endmodule

// File: rtl/fll_controller.sv
// FLL acquisition/tracking controller: integrates loop-filter error into a
// saturating NCO frequency word, switching gain between ACQUIRE and TRACK.
module fll_controller
    import fll_pkg::*;
#(
    parameter int ErrorBits     = 12,
    parameter int FreqWordBits  = 24,
    parameter int AcquireShift  = 4,
    parameter int TrackShift    = 8,
    parameter int LockThreshold = 64,
    parameter int LockCount     = 256,
    parameter int UnlockCount   = 16,
    parameter int FreqLimit     = 2 ** 20
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic                           enable_i,
    input  logic signed [ErrorBits-1:0]    err_i,
    input  logic                           err_valid_i,
    output logic                           err_ready_o,
    output logic signed [FreqWordBits-1:0] freq_word_o,
    output logic                           freq_word_valid_o,
    input  logic                           freq_word_ready_i,
    output logic                           locked_o,
    output logic [1:0]                     state_o,
    output logic                           saturated_o
);

    localparam int SumBits = FreqWordBits + 1;

    fll_state_t                     state_q, state_d;
    logic signed [FreqWordBits-1:0] freq_word_q, freq_word_d;
    logic                           valid_q, valid_d;
    logic                           sat_q, sat_d;
    logic                           locked_q;

    logic                           accept;
    logic                           clear_counters;
    logic                           in_lock_reached, out_lock_reached;
    logic signed [SumBits-1:0]      err_ext, step, sum;
    logic                           clipped;

    assign err_ready_o    = enable_i && (state_q != IDLE) && (!valid_q || freq_word_ready_i);
    assign accept         = err_valid_i && err_ready_o;
    assign clear_counters = !enable_i || (state_q == IDLE);

    lock_detector #(
        .ErrorBits     (ErrorBits),
        .LockThreshold (LockThreshold),
        .LockCount     (LockCount),
        .UnlockCount   (UnlockCount)
    ) u_lock_detector (
        .clk_i              (clk_i),
        .rst_ni             (rst_ni),
        .sample_i           (accept),
        .clear_i            (clear_counters),
        .err_i              (err_i),
        .in_lock_reached_o  (in_lock_reached),
        .out_lock_reached_o (out_lock_reached)
    );

    // Gain follows the state in the accepting cycle; sum has one guard bit.
    always_comb begin
        err_ext = SumBits'(err_i);
        step    = (state_q == TRACK) ? (err_ext >>> TrackShift) : (err_ext >>> AcquireShift);
        sum     = SumBits'(freq_word_q) + step;
        clipped = exceeds_limit(64'(sum), 64'(FreqLimit));
    end

    always_comb begin
        state_d     = state_q;
        freq_word_d = freq_word_q;
        valid_d     = valid_q;
        sat_d       = sat_q;
        if (!enable_i) begin
            state_d     = IDLE;
            freq_word_d = '0;
            valid_d     = 1'b0;
            sat_d       = 1'b0;
        end else if (state_q == IDLE) begin
            state_d = ACQUIRE;
        end else if (accept) begin
            freq_word_d = FreqWordBits'(saturate(64'(sum), 64'(FreqLimit)));
            valid_d     = 1'b1;
            sat_d       = clipped;
            if (state_q == ACQUIRE && in_lock_reached) begin
                state_d = TRACK;
            end else if (state_q == TRACK && out_lock_reached) begin
                state_d = ACQUIRE;
            end
        end else if (valid_q && freq_word_ready_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            freq_word_q <= '0;
            valid_q     <= 1'b0;
            sat_q       <= 1'b0;
            locked_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            freq_word_q <= freq_word_d;
            valid_q     <= valid_d;
            sat_q       <= sat_d;
            locked_q    <= (state_d == TRACK);
        end
    end

    assign freq_word_o       = freq_word_q;
    assign freq_word_valid_o = valid_q;
    assign saturated_o       = sat_q;
    assign locked_o          = locked_q;
    assign state_o           = state_q;

endmodule

// File: tb/tb_fll_controller.sv
// Scoreboard bench for fll_controller: directed scenarios followed by random
// traffic, checked against an integer reference model of the loop.
module tb_fll_controller;

    localparam int ErrorBits     = 12;
    localparam int FreqWordBits  = 24;
    localparam int AcquireShift  = 4;
    localparam int TrackShift    = 8;
    localparam int LockThreshold = 64;
    localparam int LockCount     = 256;
    localparam int UnlockCount   = 16;
    localparam int FreqLimit     = 1 << 20;

    typedef struct {
        int freq;
        bit sat;
        int st;
    } expect_t;

    logic                           clk = 1'b0;
    logic                           rstN;
    logic                           enable;
    logic signed [ErrorBits-1:0]    err;
    logic                           errValid;
    logic                           errReady;
    logic signed [FreqWordBits-1:0] freqWord;
    logic                           freqWordValid;
    logic                           freqWordReady;
    logic                           locked;
    logic [1:0]                     state;
    logic                           saturated;

    int      checks   = 0;
    int      failures = 0;
    expect_t sb[$];

    int mState, mFreq, inRun, outRun;
    bit mSat, mValid, lastAccepted;

    fll_controller #(
        .ErrorBits     (ErrorBits),
        .FreqWordBits  (FreqWordBits),
        .AcquireShift  (AcquireShift),
        .TrackShift    (TrackShift),
        .LockThreshold (LockThreshold),
        .LockCount     (LockCount),
        .UnlockCount   (UnlockCount),
        .FreqLimit     (FreqLimit)
    ) dut (
        .clk_i             (clk),
        .rst_ni            (rstN),
        .enable_i          (enable),
        .err_i             (err),
        .err_valid_i       (errValid),
        .err_ready_o       (errReady),
        .freq_word_o       (freqWord),
        .freq_word_valid_o (freqWordValid),
        .freq_word_ready_i (freqWordReady),
        .locked_o          (locked),
        .state_o           (state),
        .saturated_o       (saturated)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic signed [63:0] actual,
                               input logic signed [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0d expected=%0d at %0t", name, actual, expected, $time);
        end
    endtask

    // Floor division by a power of two, written without shifts.
    function automatic int floorDiv(input int v, input int sh);
        int d;
        int q;
        d = 1;
        for (int k = 0; k < sh; k++) d = d * 2;
        q = v / d;
        if ((v % d) != 0 && v < 0) q = q - 1;
        return q;
    endfunction

    task automatic modelStep(input bit en, input bit ev, input int e, input bit rdy);
        int      mag;
        int      nf;
        bit      acc;
        expect_t x;
        acc = ev && en && (mState != 0) && (!mValid || rdy);
        if (!en) begin
            if (mValid && !rdy) void'(sb.pop_back());
            mState = 0; mFreq = 0; mValid = 0; mSat = 0; inRun = 0; outRun = 0;
        end else if (mState == 0) begin
            mState = 1;
        end else if (acc) begin
            mag = (e < 0) ? -e : e;
            if (mag <= LockThreshold) begin
                outRun = 0;
                if (inRun < LockCount) inRun++;
            end else begin
                inRun = 0;
                if (outRun < UnlockCount) outRun++;
            end
            nf   = mFreq + floorDiv(e, (mState == 2) ? TrackShift : AcquireShift);
            mSat = 0;
            if (nf > FreqLimit) begin
                nf = FreqLimit; mSat = 1;
            end else if (nf < -FreqLimit) begin
                nf = -FreqLimit; mSat = 1;
            end
            mFreq = nf;
            if (mState == 1 && inRun == LockCount) begin
                mState = 2; outRun = 0;
            end else if (mState == 2 && outRun == UnlockCount) begin
                mState = 1; inRun = 0;
            end
            mValid = 1;
            x.freq = mFreq; x.sat = mSat; x.st = mState;
            sb.push_back(x);
        end else if (mValid && rdy) begin
            mValid = 0;
        end
        lastAccepted = acc;
    endtask

    // Drive one cycle, compare visible registered state with the model, then advance it.
    task automatic applyStimulus(input bit en, input bit ev, input int e, input bit rdy);
        bit expReady;
        @(negedge clk);
        enable        = en;
        errValid      = ev;
        err           = e[ErrorBits-1:0];
        freqWordReady = rdy;
        #1;
        expReady = en && (mState != 0) && (!mValid || rdy);
        checkOutput("err_ready", errReady, expReady);
        checkOutput("state", state, mState);
        checkOutput("locked", locked, mState == 2);
        checkOutput("freq_word_valid", freqWordValid, mValid);
        checkOutput("freq_word", freqWord, mFreq);
        if (mState != 0) checkOutput("saturated", saturated, mSat);
        modelStep(en, ev, e, rdy);
    endtask

    task automatic feed(input int e, input int n);
        int got;
        int cyc;
        got = 0;
        cyc = 0;
        while (got < n && cyc < 4 * n + 10) begin
            applyStimulus(1'b1, 1'b1, e, 1'b1);
            if (lastAccepted) got++;
            cyc++;
        end
        checkOutput("feed_accepts", got, n);
    endtask

    // Monitor: every consumed word must match the oldest outstanding expectation.
    always @(negedge clk) begin
        expect_t x;
        #2;
        if (rstN === 1'b1 && freqWordValid === 1'b1 && freqWordReady === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("[TB] FAIL sb_unexpected_word actual=%0d expected=none", freqWord);
            end else begin
                x = sb.pop_front();
                checkOutput("sb_freq", freqWord, x.freq);
                checkOutput("sb_sat", saturated, x.sat);
                checkOutput("sb_state", state, x.st);
                checkOutput("sb_locked", locked, x.st == 2);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int  cyc;
        bit  en, ev, rdy, smallMode;
        int  e;
        int  pick;

        rstN = 1'b0; enable = 1'b0; errValid = 1'b1; err = '0; freqWordReady = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        checkOutput("rst_state", state, 0);
        checkOutput("rst_locked", locked, 0);
        checkOutput("rst_valid", freqWordValid, 0);
        checkOutput("rst_freq", freqWord, 0);
        checkOutput("rst_sat", saturated, 0);
        checkOutput("rst_ready", errReady, 0);
        mState = 0; mFreq = 0; mValid = 0; mSat = 0; inRun = 0; outRun = 0;
        rstN = 1'b1;

        repeat (4) applyStimulus(1'b0, 1'b1, 100, 1'b1);

        feed(160, 10);
        applyStimulus(1'b1, 1'b0, 0, 1'b1);
        checkOutput("acq_freq", freqWord, 100);
        checkOutput("acq_state", state, 1);

        feed(32, LockCount);
        applyStimulus(1'b1, 1'b1, 32, 1'b1);
        checkOutput("lock_state", state, 2);
        checkOutput("lock_locked", locked, 1);
        applyStimulus(1'b1, 1'b1, -1, 1'b1);
        checkOutput("track_shift_freq", freqWord, 612);
        applyStimulus(1'b1, 1'b0, 0, 1'b1);
        checkOutput("track_minus1_freq", freqWord, 611);

        feed(500, 15);
        feed(0, 1);
        applyStimulus(1'b1, 1'b0, 0, 1'b1);
        checkOutput("no_unlock_state", state, 2);
        feed(500, UnlockCount);
        applyStimulus(1'b1, 1'b0, 0, 1'b1);
        checkOutput("unlock_state", state, 1);
        checkOutput("unlock_freq", freqWord, 642);

        cyc = 0;
        while (!mSat && cyc < 9000) begin
            applyStimulus(1'b1, 1'b1, 2047, 1'b1);
            cyc++;
        end
        checkOutput("sat_reached", mSat, 1);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, 1'b1, -2048, 1'b0);
            checkOutput("stall_ready", errReady, 0);
            checkOutput("stall_freq", freqWord, FreqLimit);
            checkOutput("stall_sat", saturated, 1);
        end
        applyStimulus(1'b1, 1'b1, -2048, 1'b1);
        applyStimulus(1'b1, 1'b0, 0, 1'b1);
        checkOutput("desat_freq", freqWord, 1048448);
        checkOutput("desat_sat", saturated, 0);

        feed(0, LockCount);
        applyStimulus(1'b1, 1'b0, 0, 1'b1);
        checkOutput("relock_state", state, 2);
        applyStimulus(1'b0, 1'b1, 100, 1'b1);
        applyStimulus(1'b0, 1'b0, 0, 1'b1);
        checkOutput("disable_state", state, 0);
        checkOutput("disable_freq", freqWord, 0);
        checkOutput("disable_valid", freqWordValid, 0);
        checkOutput("disable_locked", locked, 0);

        smallMode = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            if (i % 600 == 0) smallMode = ($urandom_range(0, 2) != 0);
            en  = ($urandom_range(0, 299) != 0);
            ev  = ($urandom_range(0, 9) != 0);
            rdy = ($urandom_range(0, 7) != 0);
            if (smallMode) begin
                e = int'($urandom_range(0, 128)) - 64;
            end else begin
                pick = int'($urandom_range(0, 7));
                case (pick)
                    0: e = 65;
                    1: e = -65;
                    2: e = -2048;
                    3: e = 2047;
                    default: e = int'($urandom_range(0, 4095)) - 2048;
                endcase
            end
            applyStimulus(en, ev, e, rdy);
        end

        repeat (3) applyStimulus(1'b1, 1'b0, 0, 1'b1);
        checkOutput("sb_drained", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fll_controller.md
# fll_controller

Acquisition and tracking controller for the frequency-locked loop. Consumes the filtered frequency-error stream from the FLL loop filter and integrates it into a signed NCO frequency word. Sequences the loop through idle, wide-bandwidth acquisition and narrow-bandwidth tracking by switching the integrator gain. Publishes a lock indication from consecutive-sample error statistics.

## Interface
Parameters:
- ErrorBits, 12, width of signed loop-filter error input
- FreqWordBits, 24, width of signed NCO frequency word
- AcquireShift, 4, arithmetic right shift applied to error in ACQUIRE (high gain)
- TrackShift, 8, arithmetic right shift applied to error in TRACK (low gain)
- LockThreshold, 64, |err| <= this counts as an "in-lock" sample
- LockCount, 256, consecutive in-lock samples to enter TRACK
- UnlockCount, 16, consecutive out-of-lock samples to fall back to ACQUIRE
- FreqLimit, 2^20, saturation magnitude of the frequency word (must be < 2^(FreqWordBits-1))

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset; synchronous, active-low
- enable  in  1  run the loop; low forces IDLE
- err  in  ErrorBits  signed error sample from loop filter
- err_valid  in  1  err is valid
- err_ready  out  1  controller accepts err this cycle
- freq_word  out  FreqWordBits  signed NCO frequency word
- freq_word_valid  out  1  freq_word holds an unconsumed update
- freq_word_ready  in  1  NCO consumes freq_word
- locked  out  1  high while in TRACK
- state  out  2  current state (IDLE=0, ACQUIRE=1, TRACK=2)
- saturated  out  1  last update clipped at ±FreqLimit

## Operation
- States: IDLE, ACQUIRE, TRACK.
- IDLE: err_ready=0; freq_word held at 0; counters cleared. enable=1 -> ACQUIRE next cycle.
- Accept: a sample is accepted when err_valid && err_ready. err_ready = enable && state!=IDLE && (!freq_word_valid || freq_word_ready).
- Update on accept: freq_word <= sat(freq_word + (sext(err) >>> shift)). shift=AcquireShift in ACQUIRE, TrackShift in TRACK. The shift is arithmetic with floor rounding, so -1 >>> 4 = -1. The sum is computed at FreqWordBits+1 bits. sat clips to [-FreqLimit, +FreqLimit] and sets saturated; saturated is cleared on any unclipped update.
- The gain used is the one of the state in the cycle of acceptance.
- Magnitude: |err| computed at ErrorBits+1 bits, so -2^(ErrorBits-1) is handled without overflow.
- Lock counters update only on accepted samples. Both counters saturate at their target and never wrap.
  - in_cnt: +1 if |err|<=LockThreshold, else cleared.
  - out_cnt: +1 if |err|>LockThreshold, else cleared.
- ACQUIRE -> TRACK when the accepted sample makes in_cnt reach LockCount. out_cnt is cleared on entry.
- TRACK -> ACQUIRE when the accepted sample makes out_cnt reach UnlockCount. in_cnt is cleared on entry. freq_word is retained.
- enable=0 in any state -> IDLE next cycle, with freq_word=0, freq_word_valid=0 and counters cleared. A sample presented in that cycle is not accepted.
- locked = (state==TRACK), registered.

## Timing
- Reset values: freq_word=0, freq_word_valid=0, err_ready=0, locked=0, state=IDLE, saturated=0, counters=0.
- Reset mid-operation discards any pending freq_word update.
- Latency: sample accepted at cycle N -> updated freq_word and freq_word_valid=1 at N+1.
- State transitions and locked change at N+1.
- freq_word_valid stays high and freq_word stays stable until freq_word_ready.
- Simultaneous consume and accept in one cycle: the new word replaces the old and valid stays high, giving full throughput of 1 sample/cycle.
- Stall: with freq_word_valid=1 and freq_word_ready=0, err_ready=0 and no state or counter changes occur.
- Coincident events: enable falling has priority over reset-free accept; rst_n low has priority over everything.

## Structure
- Shared package fll_pkg holds:
  - enum fll_state_t {IDLE, ACQUIRE, TRACK} (2 bits)
  - state encoding constants
  - the saturate function, reused by the NCO.
- One sub-module, lock_detector: threshold compare plus the two saturating consecutive-sample counters. It takes a sample strobe and a clear input, and outputs in_lock_reached and out_lock_reached.
- The controller FSM, integrator and output register live in fll_controller.

## Test plan
- Reset/idle: rst_n=0 for 3 cycles, then enable=0 with err_valid=1 -> err_ready=0, freq_word=0, state=0, locked=0 throughout.
- Acquire gain: enable=1, feed err=+160 ten times with freq_word_ready=1 -> freq_word increments by 10 per sample to 100. Each update appears one cycle after acceptance. state=1.
- Lock entry: defaults, feed err=+32 continuously -> state=2 and locked=1 exactly one cycle after the 256th accepted sample. The next update then uses shift 8 (32>>>8 = 0, so freq_word is unchanged). err=-1 gives a -1 step.
- Unlock: in TRACK, feed 15 samples err=+500, one err=0, then 16 samples err=+500 -> no unlock after the first burst. Return to ACQUIRE one cycle after the 16th sample of the second burst, with freq_word retained.
- Saturation/backpressure: ACQUIRE, err=+2047 repeated until freq_word=+1048576 with saturated=1. Then hold freq_word_ready=0 for 5 cycles -> err_ready=0, freq_word stable, no counter change. Then err=-2048 -> freq_word=1048448, saturated=0.
- Disable mid-run: in TRACK, drop enable with a valid sample pending -> sample not accepted, next cycle state=0, freq_word=0, freq_word_valid=0, locked=0.
